// File: rtl/sync_fifo_slave.sv
// sync_fifo_slave: single-clock responder-side FIFO with occupancy flags
// and a one-cycle error pulse for illegal push/pop requests.
module sync_fifo_slave #(
   parameter int WIDTH        = 32,
   parameter int BIT_DEPTH    = 4,
   parameter int FULL         = 2**BIT_DEPTH,
   parameter int ALMOST_FULL  = 3*FULL/4,
   parameter int ALMOST_EMPTY = FULL/4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             empty,
   output logic             error
);

   localparam logic [BIT_DEPTH:0] C_FULL = (BIT_DEPTH+1)'(FULL);
   localparam logic [BIT_DEPTH:0] C_AF   = (BIT_DEPTH+1)'(ALMOST_FULL);
   localparam logic [BIT_DEPTH:0] C_AE   = (BIT_DEPTH+1)'(ALMOST_EMPTY);

   logic [WIDTH-1:0]     r_mem [FULL];
   logic [BIT_DEPTH-1:0] r_wr_ptr;
   logic [BIT_DEPTH-1:0] r_rd_ptr;
   logic [BIT_DEPTH:0]   r_count;
   logic [WIDTH-1:0]     r_data_out;
   logic                 r_error;

   logic w_pop_ok;
   logic w_push_ok;
   logic w_illegal;

   // Acceptance depends only on push/pop and count, never on data_in, so an
   // X data word cannot leak into the flags or the error pulse. A push at
   // full is legal only when a pop frees the head slot on the same edge.
   always_comb begin
      w_pop_ok  = pop && (r_count != '0);
      w_push_ok = push && ((r_count != C_FULL) || w_pop_ok);
      w_illegal = (push && !w_push_ok) || (pop && !w_pop_ok);
   end

   // Storage write; not reset, contents are don't-care until pushed.
   always_ff @(posedge clk) begin
      if (w_push_ok && reset_n)
         r_mem[r_wr_ptr] <= data_in;
   end

   // Pointers wrap naturally at FULL since the depth is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Occupancy: simultaneous accepted push and pop leave it unchanged.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else begin
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Registered read data (holds when no legal pop) and error pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data_out <= '0;
         r_error    <= 1'b0;
      end else begin
         if (w_pop_ok) r_data_out <= r_mem[r_rd_ptr];
         r_error <= w_illegal;
      end
   end

   // Flags decode the registered count only.
   always_comb begin
      empty        = (r_count == '0);
      full         = (r_count == C_FULL);
      almost_full  = (r_count >= C_AF);
      almost_empty = (r_count != '0) && (r_count <= C_AE);
   end

   assign data_out = r_data_out;
   assign error    = r_error;

endmodule

// File: tb/tb_sync_fifo_slave.sv
// tb_sync_fifo_slave: queue-based reference model plus per-cycle compare,
// directed scenarios with literal expectations, and a random wrap phase.
module tb_sync_fifo_slave;

   logic        clk;
   logic        reset_n;
   logic        push;
   logic        pop;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        full;
   logic        almost_full;
   logic        almost_empty;
   logic        empty;
   logic        error;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;
   bit dead_seen = 0;
   int rand_err_cnt = 0;
   bit in_rand = 0;

   sync_fifo_slave #(.WIDTH(32), .BIT_DEPTH(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .push         (push),
      .pop          (pop),
      .data_in      (data_in),
      .data_out     (data_out),
      .full         (full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .empty        (empty),
      .error        (error)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Reference model: front = newest, back = oldest.
   logic [31:0] q[$];
   logic [31:0] m_dout;
   logic        m_err;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         m_dout = 32'h0;
         m_err  = 1'b0;
      end else begin
         bit pop_ok, push_ok;
         pop_ok  = pop && (q.size() > 0);
         push_ok = push && ((q.size() < 16) || pop_ok);
         m_err   = (push && !push_ok) || (pop && !pop_ok);
         if (pop_ok)  m_dout = q.pop_back();
         if (push_ok) q.push_front(data_in);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         int n;
         n = q.size();
         chk("empty",        empty,        n == 0);
         chk("full",         full,         n == 16);
         chk("almost_full",  almost_full,  n >= 12);
         chk("almost_empty", almost_empty, (n != 0) && (n <= 4));
         chk("error",        error,        m_err);
         chk("data_out",     data_out,     m_dout);
         if (data_out === 32'hDEAD) dead_seen = 1;
         if (in_rand && error !== 1'b0) rand_err_cnt++;
      end
   end

   // Drive one cycle's request at a negedge; returns at the next negedge.
   task automatic step(input logic p, input logic r, input logic [31:0] d);
      push = p; pop = r; data_in = d;
      @(negedge clk);
   endtask

   initial begin
      reset_n = 0; push = 0; pop = 0; data_in = '0;
      repeat (2) @(negedge clk);
      reset_n = 1;
      chk_en = 1;
      step(0, 0, 0);
      // reset / idle literals
      chk("rst_empty", empty, 1);
      chk("rst_ae", almost_empty, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_full", full, 0);
      chk("rst_err", error, 0);
      chk("rst_dout", data_out, 32'h0);

      // fill 0x10..0x1F with flag thresholds
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 32'h10 + i);
         if (i == 0)  chk("ae_after1", almost_empty, 1);
         if (i == 3)  chk("ae_after4", almost_empty, 1);
         if (i == 4)  chk("ae_after5", almost_empty, 0);
         if (i == 10) chk("af_after11", almost_full, 0);
         if (i == 11) chk("af_after12", almost_full, 1);
         if (i == 14) chk("full_after15", full, 0);
      end
      chk("full_after16", full, 1);

      // overflow push: dropped, one-cycle error
      step(1, 0, 32'hDEAD);
      chk("ovf_err", error, 1);
      chk("ovf_full", full, 1);
      step(0, 0, 0);
      chk("ovf_err_clear", error, 0);

      // drain in order
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 0);
         chk("drain_data", data_out, 32'h10 + i);
      end
      chk("drain_empty", empty, 1);
      chk("no_dead", dead_seen, 0);

      // underflow pop
      step(0, 1, 0);
      chk("unf_err", error, 1);
      chk("unf_dout", data_out, 32'h1F);
      // push+pop while empty: push kept, pop ignored
      step(1, 1, 32'hA5);
      chk("pp_empty_err", error, 1);
      chk("pp_empty_ae", almost_empty, 1);
      chk("pp_empty_dout", data_out, 32'h1F);
      step(0, 1, 0);
      chk("pp_empty_pop", data_out, 32'hA5);
      chk("pp_empty_err0", error, 0);

      // push+pop at full
      for (int i = 0; i < 16; i++) step(1, 0, 32'h100 + i);
      step(1, 1, 32'h55);
      chk("ppf_dout", data_out, 32'h100);
      chk("ppf_full", full, 1);
      chk("ppf_err", error, 0);
      for (int i = 0; i < 16; i++) step(0, 1, 0);
      chk("ppf_last", data_out, 32'h55);
      chk("ppf_empty", empty, 1);

      // X data stored as-is, flags stay clean
      step(1, 0, 'x);
      step(0, 1, 0);
      chk("x_empty", empty, 1);

      // random interleave at mid occupancy
      for (int i = 0; i < 8; i++) step(1, 0, $urandom);
      in_rand = 1;
      for (int i = 0; i < 40; i++) begin
         logic p, r;
         p = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         if (q.size() <= 2)  begin p = 1; r = 0; end
         if (q.size() >= 14) begin p = 0; r = 1; end
         step(p, r, $urandom);
      end
      in_rand = 0;
      chk("rand_no_error", rand_err_cnt, 0);
      while (q.size() > 0) step(0, 1, 0);
      chk("rand_drained", empty, 1);

      // async reset mid-stream at count 7, data_out non-zero
      for (int i = 0; i < 8; i++) step(1, 0, 32'h200 + i);
      step(0, 1, 0);
      chk("pre_rst_dout", data_out, 32'h200);
      #2 reset_n = 0;
      #1;
      chk("arst_empty", empty, 1);
      chk("arst_ae", almost_empty, 0);
      chk("arst_af", almost_full, 0);
      chk("arst_full", full, 0);
      chk("arst_dout", data_out, 32'h0);
      chk("arst_err", error, 0);
      push = 1; pop = 1; data_in = 32'hBEEF;
      @(negedge clk);
      push = 0; pop = 0;
      reset_n = 1;
      step(0, 0, 0);
      chk("post_rst_empty", empty, 1);
      chk("post_rst_dout", data_out, 32'h0);

      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
